conv_frame_ctrl: RTL



---
 rtl/conv_frame_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_frame_ctrl.sv
// ---------------------------------------------------------------------------
// conv_frame_ctrl
//   Layer-level sequencer for the streaming convolution path. For each of
//   num_ch input channels it streams one WIDTH x HEIGHT feature map out of
//   feature-map RAM, waits for the border-truncation stage to report the
//   frame as done, then moves on. A single layer_done pulse closes the layer.
//
// Optional feature (macro CTRL_TIMEOUT_EN):
//   Defined   : a drain watchdog sets the sticky err flag after DRAIN_TIMEOUT
//               DRAIN cycles without a frame-done, and forces the drain exit.
//   Undefined : err is tied to 0 and DRAIN waits for frame-done indefinitely.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   start         one-cycle layer request (ignored while busy)
//   num_ch        channel count, sampled on an accepted start
//   stall         downstream not ready, suppresses new reads
//   trunc_done    frame-done pulse from the truncation stage
//   rd_en/rd_addr RAM read strobe and address
//   pix_valid     rd_en delayed by RD_LAT cycles (pipeline valid_in)
//   ch_idx        current channel index
//   frame_start   one-cycle pulse in the first STREAM cycle of a channel
//   busy          high in every state except IDLE
//   layer_done    one-cycle completion pulse
//   err           sticky drain-timeout flag
//   state_dbg     current FSM state (IDLE=0, STREAM=1, DRAIN=2, DONE=3)
//
// Handshake: a read is issued in every STREAM cycle where stall is low
// (rd_en=1 with rd_addr valid); the read data is valid RD_LAT cycles later,
// flagged by pix_valid. The delay line never stalls.
// ---------------------------------------------------------------------------
module conv_frame_ctrl #(
    parameter int WIDTH         = 28,
    parameter int HEIGHT        = 28,
    parameter int ADDR_W        = 16,
    parameter int RD_LAT        = 1,
    parameter int DRAIN_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        num_ch,
    input  logic              stall,
    input  logic              trunc_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic [7:0]        ch_idx,
    output logic              frame_start,
    output logic              busy,
    output logic              layer_done,
    output logic              err,
    output logic [1:0]        state_dbg
);

    localparam int FRAME = WIDTH * HEIGHT;
    localparam int PIX_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(FRAME - 1);
    localparam logic [ADDR_W-1:0] FRAME_A  = ADDR_W'(FRAME);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e            state_q;
    logic [PIX_W-1:0]  pix_q;
    logic [ADDR_W-1:0] ch_base_q;
    logic [7:0]        ch_idx_q;
    logic [7:0]        num_q;
    logic              done_seen_q;
    logic [RD_LAT-1:0] dly_q;
    logic              frame_start_q;
    logic              err_q;

    logic done_now;
    logic timeout_hit;
    logic drain_exit;
    logic last_ch;

    assign rd_en       = (state_q == S_STREAM) && !stall;
    assign rd_addr     = ch_base_q + ADDR_W'(pix_q);
    assign pix_valid   = dly_q[RD_LAT-1];
    assign ch_idx      = ch_idx_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != S_IDLE);
    assign layer_done  = (state_q == S_DONE);
    assign err         = err_q;
    assign state_dbg   = state_q;

    // A frame-done arriving in the same cycle counts as already seen.
    assign done_now = done_seen_q || trunc_done;
    assign last_ch  = ((ch_idx_q + 8'd1) == num_q);

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    logic [CNT_W-1:0] drain_cnt_q;
    // drain_cnt_q holds the number of completed DRAIN cycles, so the
    // DRAIN_TIMEOUT-th DRAIN cycle sees DRAIN_TIMEOUT-1.
    assign timeout_hit = (state_q == S_DRAIN) && !done_now &&
                         (drain_cnt_q >= CNT_W'(DRAIN_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Leave DRAIN only once every in-flight read has emerged on pix_valid.
    assign drain_exit = (state_q == S_DRAIN) && (done_now || timeout_hit) &&
                        (dly_q == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            pix_q         <= '0;
            ch_base_q     <= '0;
            ch_idx_q      <= '0;
            num_q         <= '0;
            done_seen_q   <= 1'b0;
            dly_q         <= '0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            drain_cnt_q   <= '0;
`endif
        end else begin
            dly_q         <= (dly_q << 1) | RD_LAT'(rd_en);
            frame_start_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_ch == 8'd0) begin
                            state_q <= S_DONE;
                        end else begin
                            num_q         <= num_ch;
                            ch_idx_q      <= 8'd0;
                            ch_base_q     <= '0;
                            pix_q         <= '0;
                            done_seen_q   <= 1'b0;
                            frame_start_q <= 1'b1;
                            state_q       <= S_STREAM;
                        end
                    end
                end

                S_STREAM: begin
                    if (trunc_done) begin
                        done_seen_q <= 1'b1;
                    end
                    if (rd_en) begin
                        if (pix_q == PIX_LAST) begin
                            pix_q   <= '0;
                            state_q <= S_DRAIN;
`ifdef CTRL_TIMEOUT_EN
                            drain_cnt_q <= '0;
`endif
                        end else begin
                            pix_q <= pix_q + PIX_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (trunc_done) begin
                        done_seen_q <= 1'b1;
                    end
`ifdef CTRL_TIMEOUT_EN
                    if (drain_cnt_q < CNT_W'(DRAIN_TIMEOUT)) begin
                        drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                    end
`endif
                    if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                    if (drain_exit) begin
                        if (last_ch) begin
                            state_q <= S_DONE;
                        end else begin
                            ch_idx_q      <= ch_idx_q + 8'd1;
                            ch_base_q     <= ch_base_q + FRAME_A;
                            done_seen_q   <= 1'b0;
                            frame_start_q <= 1'b1;
                            state_q       <= S_STREAM;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
